// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: FSM state encoding, HLT opcode and the bubble word.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int               OPC_W  = 4;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;
    localparam logic [15:0]      BUBBLE = 16'h0000;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Two 16-bit saturating event counters (stall cycles, redirects); 1-cycle update, no backpressure.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_inc,
    input  logic        i_flush_inc,
    output logic [15:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
);

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (i_stall_inc && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (i_flush_inc && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: 1-cycle fetch latency; stall holds PC and IF/ID, redirect flushes.
// Optional perf counters under FETCH_PERF_CNT_EN (ports read 0 otherwise).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_ifid_instr,
    output logic [PC_W-1:0]    o_ifid_pc_plus1,
    output logic               o_ifid_valid,
    output logic               o_halted,
    output logic [15:0]        o_perf_stall_cnt,
    output logic [15:0]        o_perf_flush_cnt
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    w_pc_plus1;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [INSTR_W-1:0] w_ifid_instr_nxt;
    logic [PC_W-1:0]    r_ifid_pc_plus1;
    logic [PC_W-1:0]    w_ifid_pc_plus1_nxt;
    logic               r_ifid_valid;
    logic               w_ifid_valid_nxt;
    logic               w_ifid_hlt;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    // HLT is detected once it sits in IF/ID, so it still reaches decode as a real instruction.
    assign w_ifid_hlt = r_ifid_valid && (r_ifid_instr[INSTR_W-1 -: OPC_W] == OP_HLT);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                if (!i_redirect && !i_stall && w_ifid_hlt)
                    w_state_nxt = S_HALT;
            end
            S_HALT: begin
                if (i_redirect)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_pc_nxt            = r_pc;
        w_ifid_instr_nxt    = r_ifid_instr;
        w_ifid_pc_plus1_nxt = r_ifid_pc_plus1;
        w_ifid_valid_nxt    = r_ifid_valid;
        o_halted            = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_redirect) begin
                    w_pc_nxt         = i_redirect_pc;
                    w_ifid_instr_nxt = INSTR_W'(BUBBLE);
                    w_ifid_valid_nxt = 1'b0;
                end else if (!i_stall) begin
                    if (w_ifid_hlt) begin
                        w_ifid_instr_nxt = INSTR_W'(BUBBLE);
                        w_ifid_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt            = w_pc_plus1;
                        w_ifid_instr_nxt    = i_imem_rdata;
                        w_ifid_pc_plus1_nxt = w_pc_plus1;
                        w_ifid_valid_nxt    = 1'b1;
                    end
                end
            end
            S_HALT: begin
                o_halted         = 1'b1;
                w_ifid_instr_nxt = INSTR_W'(BUBBLE);
                w_ifid_valid_nxt = 1'b0;
                if (i_redirect)
                    w_pc_nxt = i_redirect_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= INSTR_W'(BUBBLE);
            r_ifid_pc_plus1 <= '0;
            r_ifid_valid    <= 1'b0;
        end else begin
            r_pc            <= w_pc_nxt;
            r_ifid_instr    <= w_ifid_instr_nxt;
            r_ifid_pc_plus1 <= w_ifid_pc_plus1_nxt;
            r_ifid_valid    <= w_ifid_valid_nxt;
        end
    end

    assign o_imem_addr     = r_pc;
    assign o_ifid_instr    = r_ifid_instr;
    assign o_ifid_pc_plus1 = r_ifid_pc_plus1;
    assign o_ifid_valid    = r_ifid_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_inc;
    assign w_stall_inc = (r_state == S_RUN) && i_stall && !i_redirect;

    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_stall_inc (w_stall_inc),
        .i_flush_inc (i_redirect),
        .o_stall_cnt (o_perf_stall_cnt),
        .o_flush_cnt (o_perf_flush_cnt)
    );
`else
    assign o_perf_stall_cnt = 16'h0000;
    assign o_perf_flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic against a cycle model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr, imem_rdata, ifid_instr, ifid_pc_plus1;
    logic        ifid_valid, halted;
    logic [15:0] perf_stall_cnt, perf_flush_cnt;

    logic        rst2;
    logic [15:0] imem_addr2, imem_rdata2, ifid_instr2, ifid_pc_plus1_2;
    logic        ifid_valid2, halted2;
    logic [15:0] perf_stall_cnt2, perf_flush_cnt2;

    logic [15:0] imem [0:65535];
    assign imem_rdata  = imem[imem_addr];
    assign imem_rdata2 = imem[imem_addr2];

    fetch_stage dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .o_ifid_instr(ifid_instr), .o_ifid_pc_plus1(ifid_pc_plus1), .o_ifid_valid(ifid_valid),
        .o_halted(halted), .o_perf_stall_cnt(perf_stall_cnt), .o_perf_flush_cnt(perf_flush_cnt)
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst2), .i_stall(1'b0), .i_redirect(1'b0),
        .i_redirect_pc(16'h0000), .o_imem_addr(imem_addr2), .i_imem_rdata(imem_rdata2),
        .o_ifid_instr(ifid_instr2), .o_ifid_pc_plus1(ifid_pc_plus1_2), .o_ifid_valid(ifid_valid2),
        .o_halted(halted2), .o_perf_stall_cnt(perf_stall_cnt2), .o_perf_flush_cnt(perf_flush_cnt2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural view of the stage.
    logic [15:0] m_pc, m_instr, m_pc1;
    bit          m_valid, m_halted, m_boot;
    int          m_nstall, m_nflush;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic model_step(input bit r, input bit s, input bit d, input logic [15:0] rp);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pc1 = 16'h0000;
            m_valid = 0; m_halted = 0; m_boot = 1; m_nstall = 0; m_nflush = 0;
            return;
        end
        if (d) m_nflush++;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 0;
            if (d) begin m_pc = rp; m_halted = 0; end
        end else if (d) begin
            m_pc = rp; m_instr = 16'h0000; m_valid = 0;
        end else if (s) begin
            m_nstall++;
        end else if (m_valid && m_instr[15:12] == 4'hF) begin
            m_halted = 1; m_instr = 16'h0000; m_valid = 0;
        end else begin
            m_instr = imem[m_pc]; m_pc1 = m_pc + 16'd1; m_valid = 1; m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check_all();
        logic [15:0] exp_s, exp_f;
`ifdef FETCH_PERF_CNT_EN
        exp_s = sat16(m_nstall);
        exp_f = sat16(m_nflush);
`else
        exp_s = 16'h0000;
        exp_f = 16'h0000;
`endif
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc_plus1", ifid_pc_plus1, m_pc1);
        chk("ifid_valid", 16'(ifid_valid), 16'(m_valid));
        chk("halted", 16'(halted), 16'(m_halted));
        chk("perf_stall_cnt", perf_stall_cnt, exp_s);
        chk("perf_flush_cnt", perf_flush_cnt, exp_f);
    endtask

    task automatic step(input bit r, input bit s, input bit d, input logic [15:0] rp);
        rst = r; stall = s; redirect = d; redirect_pc = rp;
        @(posedge clk);
        model_step(r, s, d, rp);
        #1;
        check_all();
    endtask

    initial begin
        bit          r, s, d;
        logic [15:0] rp;

        for (int i = 0; i < 65536; i++) imem[i] = 16'h1000 + 16'(i);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; rst2 = 1'b1;

        // Reset, boot bubble, then sequential fetch.
        step(1, 0, 0, 0);
        chk("rst_valid", 16'(ifid_valid), 16'h0000);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_pc", imem_addr, 16'h0000);
        step(0, 0, 0, 0);
        chk("boot_bubble", 16'(ifid_valid), 16'h0000);
        step(0, 0, 0, 0);
        chk("first_instr", ifid_instr, 16'h1000);
        chk("first_pc1", ifid_pc_plus1, 16'h0001);
        step(0, 0, 0, 0);
        chk("second_instr", ifid_instr, 16'h1001);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_stall_instr", ifid_instr, 16'h1003);

        // Two stall cycles freeze everything.
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 0);
            chk("stall_instr", ifid_instr, 16'h1003);
            chk("stall_addr", imem_addr, 16'h0004);
        end
        step(0, 0, 0, 0);
        chk("post_stall_instr", ifid_instr, 16'h1004);

        // Redirect wins over simultaneous stall.
        step(0, 1, 1, 16'h0040);
        chk("redir_valid", 16'(ifid_valid), 16'h0000);
        chk("redir_pc", imem_addr, 16'h0040);
        step(0, 0, 0, 0);
        chk("redir_instr", ifid_instr, 16'h1040);

        // HLT at address 5.
        imem[5] = 16'hF000;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
        chk("hlt_latched", ifid_instr, 16'hF000);
        chk("hlt_valid", 16'(ifid_valid), 16'h0001);
        step(0, 0, 0, 0);
        chk("halted", 16'(halted), 16'h0001);
        chk("halt_pc", imem_addr, 16'h0006);
        chk("halt_bubble", 16'(ifid_valid), 16'h0000);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("halt_pc_held", imem_addr, 16'h0006);
        step(0, 0, 1, 16'h0010);
        chk("unhalt", 16'(halted), 16'h0000);
        chk("unhalt_pc", imem_addr, 16'h0010);
        step(0, 0, 0, 0);
        chk("resume_instr", ifid_instr, 16'h1010);
        imem[5] = 16'h1005;

        // Random traffic; addresses E000-EFFF hold HLT opcodes.
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 30);
            d  = ($urandom_range(0, 99) < 10);
            rp = 16'($urandom);
            step(r, s, d, rp);
        end

        // Perf counters.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
        step(0, 0, 1, 16'h0100);
        step(0, 1, 1, 16'h0200);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall3", perf_stall_cnt, 16'd3);
        chk("perf_flush2", perf_flush_cnt, 16'd2);
        for (int k = 0; k < 70000; k++) step(0, 1, 0, 0);
        chk("perf_stall_sat", perf_stall_cnt, 16'hFFFF);
`else
        chk("perf_stall_off", perf_stall_cnt, 16'h0000);
        chk("perf_flush_off", perf_flush_cnt, 16'h0000);
`endif

        // PC wrap on the RESET_PC=FFFF instance.
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap_rst_pc", imem_addr2, 16'hFFFF);
        chk("wrap_rst_valid", 16'(ifid_valid2), 16'h0000);
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_boot_valid", 16'(ifid_valid2), 16'h0000);
        @(posedge clk); #1;
        chk("wrap_instr0", ifid_instr2, 16'h0FFF);
        chk("wrap_pc1_0", ifid_pc_plus1_2, 16'h0000);
        chk("wrap_pc", imem_addr2, 16'h0000);
        @(posedge clk); #1;
        chk("wrap_instr1", ifid_instr2, 16'h1000);
        chk("wrap_pc1_1", ifid_pc_plus1_2, 16'h0001);
        chk("wrap_halted", 16'(halted2), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
